// File: rtl/imem_loader_if.sv
// Loader-side bundle for the IMEM boot loader: host control, the incoming
// byte stream, and the write port toward the instruction RAM.
`timescale 1ns/1ps
interface imem_loader_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH:0]   num_words;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic                  mem_wren;
    logic                  busy;
    logic                  done;
    logic                  cpu_hold;

    // Host / byte source side
    modport master (
        output start, num_words, in_data, in_valid,
        input  in_ready, mem_addr, mem_din, mem_wren, busy, done, cpu_hold
    );

    // Loader side
    modport slave (
        input  start, num_words, in_data, in_valid,
        output in_ready, mem_addr, mem_din, mem_wren, busy, done, cpu_hold
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a little-endian byte stream into
// instruction words, writes them to consecutive IMEM addresses, and holds
// the core in reset until the requested number of words is in memory.
// The interface instance must be parameterised with the same WIDTH and
// ADDR_WIDTH as this module.
`timescale 1ns/1ps
module imem_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clock,
    input  logic          resetn,
    imem_loader_if.slave  bus
);
    localparam int BYTES = WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                state;
    logic [IDX_W-1:0]      byte_idx;
    logic [WIDTH-1:0]      word;
    logic [WIDTH-1:0]      next_word;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      words_left;
    logic [CNT_W-1:0]      start_count;
    logic                  last_byte;

    // Requests larger than the memory are limited to one full pass over it.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    assign start_count = clamp_count(bus.num_words);
    assign last_byte   = (byte_idx == IDX_W'(BYTES - 1));

    // Word as it will look once the byte on in_data lands in its lane.
    always_comb begin
        next_word = word;
        for (int b = 0; b < BYTES; b++) begin
            if (byte_idx == IDX_W'(b)) begin
                next_word[8*b +: 8] = bus.in_data;
            end
        end
    end

    // Load sequencer; every output is a register updated with the state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            byte_idx     <= '0;
            word         <= '0;
            addr         <= '0;
            words_left   <= '0;
            bus.in_ready <= 1'b0;
            bus.mem_wren <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.cpu_hold <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        words_left <= start_count;
                        addr       <= '0;
                        byte_idx   <= '0;
                        bus.done   <= 1'b0;
                        if (start_count == '0) begin
                            // Empty load: done rises one cycle after entering DONE.
                            state        <= DONE;
                            bus.cpu_hold <= 1'b0;
                        end else begin
                            state        <= RECV;
                            bus.in_ready <= 1'b1;
                            bus.busy     <= 1'b1;
                            bus.cpu_hold <= 1'b1;
                        end
                    end else if (state == DONE) begin
                        bus.done <= 1'b1;
                    end
                end
                RECV: begin
                    if (bus.in_valid && bus.in_ready) begin
                        word <= next_word;
                        if (last_byte) begin
                            byte_idx     <= '0;
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            bus.mem_wren <= 1'b1;
                            bus.mem_addr <= addr;
                            bus.mem_din  <= next_word;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    bus.mem_wren <= 1'b0;
                    addr         <= addr + 1'b1;
                    words_left   <= words_left - 1'b1;
                    if (words_left == CNT_W'(1)) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end else begin
                        state        <= RECV;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
